// File: rtl/id_ex_stage_pkg.sv
// Shared constants and the EX control bundle for the ID/EX pipeline register.
package id_ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  rd_we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_IDLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: a load in EX whose result the instruction in decode needs.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          id_valid_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  input  logic          ex_valid_i,
  input  logic          ex_is_load_i,
  input  logic          ex_rd_we_i,
  input  logic [AW-1:0] ex_rd_addr_i,
  output logic          load_use_o
);

  logic rd_matches;

  // x0 is never a real producer, so it can never stall decode.
  assign rd_matches = (ex_rd_addr_i != '0) &&
                      ((ex_rd_addr_i == rs1_addr_i) || (ex_rd_addr_i == rs2_addr_i));

  assign load_use_o = id_valid_i && ex_valid_i && ex_is_load_i && ex_rd_we_i && rd_matches;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold, load-use bubble and x0 zeroing.
// Optional write-back bypass/refresh of captured operands: define WB_BYPASS_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter  int mem_width = XLEN,
  parameter  int mem_depth = REG_COUNT,
  localparam int AW        = $clog2(mem_depth)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_we,
  input  logic                 is_load,
  input  logic [mem_width-1:0] pc,
  input  logic [mem_width-1:0] imm,
  input  logic [mem_width-1:0] A_in,
  input  logic [mem_width-1:0] B_in,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic [mem_width-1:0] wb_data,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 id_ready,
  output logic                 ex_valid,
  output logic                 ex_rd_we,
  output logic                 ex_is_load,
  output logic [AW-1:0]        ex_rs1_addr,
  output logic [AW-1:0]        ex_rs2_addr,
  output logic [AW-1:0]        ex_rd_addr,
  output logic [mem_width-1:0] ex_rs1_data,
  output logic [mem_width-1:0] ex_rs2_data,
  output logic [mem_width-1:0] ex_pc,
  output logic [mem_width-1:0] ex_imm
);

  ex_ctrl_t             ctrl_q, ctrl_d;
  logic [AW-1:0]        rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
  logic [mem_width-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [mem_width-1:0] pc_q, pc_d, imm_q, imm_d;
  logic                 load_use;

  function automatic logic [mem_width-1:0] pick_operand(input logic [AW-1:0]        addr,
                                                        input logic [mem_width-1:0] rf_data);
    logic [mem_width-1:0] val;
    val = rf_data;
`ifdef WB_BYPASS_EN
    if (wb_we && (wb_addr == addr)) val = wb_data;
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

`ifndef WB_BYPASS_EN
  // Without bypass the register file alone resolves write-before-read.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  hazard_detect #(.AW(AW)) u_hazard (
    .id_valid_i   (id_valid),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .ex_valid_i   (ex_valid),
    .ex_is_load_i (ex_is_load),
    .ex_rd_we_i   (ex_rd_we),
    .ex_rd_addr_i (ex_rd_addr),
    .load_use_o   (load_use)
  );

  assign id_ready = reset && ex_ready && !load_use && !flush;

  // Priority: flush > hold > bubble > load.
  always_comb begin
    ctrl_d     = ctrl_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    if (flush) begin
      ctrl_d.valid = 1'b0;
    end else if (!ex_ready) begin
`ifdef WB_BYPASS_EN
      if (wb_we && (wb_addr != '0)) begin
        if (wb_addr == rs1_addr_q) rs1_data_d = wb_data;
        if (wb_addr == rs2_addr_q) rs2_data_d = wb_data;
      end
`endif
    end else if (load_use) begin
      ctrl_d.valid   = 1'b0;
      ctrl_d.rd_we   = 1'b0;
      ctrl_d.is_load = 1'b0;
    end else begin
      ctrl_d.valid   = id_valid;
      ctrl_d.rd_we   = rd_we;
      ctrl_d.is_load = is_load;
      ctrl_d.rd_addr = REG_ADDR_W'(rd_addr);
      rs1_addr_d     = rs1_addr;
      rs2_addr_d     = rs2_addr;
      rs1_data_d     = pick_operand(rs1_addr, A_in);
      rs2_data_d     = pick_operand(rs2_addr, B_in);
      pc_d           = pc;
      imm_d          = imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= EX_CTRL_IDLE;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
    end
  end

  assign ex_valid    = ctrl_q.valid;
  assign ex_rd_we    = ctrl_q.rd_we;
  assign ex_is_load  = ctrl_q.is_load;
  assign ex_rd_addr  = AW'(ctrl_q.rd_addr);
  assign ex_rs1_addr = rs1_addr_q;
  assign ex_rs2_addr = rs2_addr_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_pc       = pc_q;
  assign ex_imm      = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_id_ex_stage;

  localparam int W  = 32;
  localparam int AW = 5;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic          valid;
    logic          rd_we;
    logic          is_load;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic [W-1:0]  pc;
    logic [W-1:0]  imm;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, rd_we, is_load, wb_we, flush, ex_ready;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr, wb_addr;
  logic [W-1:0]  pc, imm, A_in, B_in, wb_data;
  logic id_ready, ex_valid, ex_rd_we, ex_is_load;
  logic [AW-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [W-1:0]  ex_rs1_data, ex_rs2_data, ex_pc, ex_imm;
  logic [$bits(ex_t)-1:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign dut_vec = {ex_valid, ex_rd_we, ex_is_load, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
                    ex_rs1_data, ex_rs2_data, ex_pc, ex_imm};

  id_ex_stage #(.mem_width(W), .mem_depth(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_we(rd_we), .is_load(is_load), .pc(pc), .imm(imm), .A_in(A_in), .B_in(B_in),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  // Reference model: what the EX slot should hold, derived from the stage rules.
  function automatic bit model_hazard(input ex_t e);
    return id_valid && e.valid && e.is_load && e.rd_we && (e.rd != 0) &&
           ((e.rd == rs1_addr) || (e.rd == rs2_addr));
  endfunction

  function automatic logic [W-1:0] model_operand(input logic [AW-1:0] a, input logic [W-1:0] rf);
    if (a == 0) return '0;
    if (BYP && wb_we && (wb_addr == a)) return wb_data;
    return rf;
  endfunction

  function automatic ex_t model_next(input ex_t c);
    ex_t n = c;
    if (flush) n.valid = 1'b0;
    else if (!ex_ready) begin
      if (BYP && wb_we && (wb_addr != 0) && (wb_addr == c.rs1)) n.d1 = wb_data;
      if (BYP && wb_we && (wb_addr != 0) && (wb_addr == c.rs2)) n.d2 = wb_data;
    end else if (model_hazard(c)) begin
      n.valid = 1'b0; n.rd_we = 1'b0; n.is_load = 1'b0;
    end else begin
      n = '{valid: id_valid, rd_we: rd_we, is_load: is_load, rs1: rs1_addr, rs2: rs2_addr,
            rd: rd_addr, d1: model_operand(rs1_addr, A_in), d2: model_operand(rs2_addr, B_in),
            pc: pc, imm: imm};
    end
    return n;
  endfunction

  task automatic drive_idle();
    id_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rd_we = 0; is_load = 0;
    pc = 0; imm = 0; A_in = 0; B_in = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; drive_idle();
    id_valid = 1; rs1_addr = 3; A_in = '1;
    #2;
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec); end
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_id_ready: got %b want 0", id_ready); end
    tick();
    n_tests++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_load: got %b want 0", ex_valid); end
    reset = 1;
    id_valid = 1; rs1_addr = 1; A_in = 32'hA; rd_addr = 2; rd_we = 1;
    tick();
    n_tests++;
    if ({ex_valid, ex_rs1_data} !== {1'b1, 32'hA})
      begin n_fail++; $display("FAIL first_load: got %b/%h want 1/a", ex_valid, ex_rs1_data); end
  endtask

  task automatic test_plain_load();
    drive_idle();
    id_valid = 1; rs1_addr = 3; A_in = 32'h11; imm = 32'h4; rs2_addr = 4; B_in = 32'h22;
    pc = 32'h100; rd_addr = 6; rd_we = 1;
    #1;
    n_tests++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL plain_id_ready: got %b want 1", id_ready); end
    tick();
    n_tests++;
    if ({ex_valid, ex_rs1_data, ex_imm} !== {1'b1, 32'h11, 32'h4})
      begin n_fail++; $display("FAIL plain_load: got %b/%h/%h want 1/11/4", ex_valid, ex_rs1_data, ex_imm); end
    n_tests++;
    if ({ex_rs2_data, ex_pc, ex_rd_addr, ex_rs1_addr} !== {32'h22, 32'h100, 5'd6, 5'd3})
      begin n_fail++; $display("FAIL plain_fields: got %h/%h/%0d/%0d want 22/100/6/3",
                               ex_rs2_data, ex_pc, ex_rd_addr, ex_rs1_addr); end
  endtask

  task automatic test_load_use();
    drive_idle();
    id_valid = 1; rd_addr = 5; rd_we = 1; is_load = 1; rs1_addr = 1; rs2_addr = 2;
    tick();
    rd_addr = 10; is_load = 0; rs1_addr = 8; rs2_addr = 5;
    #1;
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall: got %b want 0", id_ready); end
    tick();
    n_tests++;
    if ({ex_valid, ex_rd_we, ex_is_load} !== 3'b000)
      begin n_fail++; $display("FAIL lu_bubble: got %b want 000", {ex_valid, ex_rd_we, ex_is_load}); end
    n_tests++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", id_ready); end
    tick();
    n_tests++;
    if ({ex_valid, ex_rs2_addr, ex_rd_addr} !== {1'b1, 5'd5, 5'd10})
      begin n_fail++; $display("FAIL lu_reload: got %b/%0d/%0d want 1/5/10", ex_valid, ex_rs2_addr, ex_rd_addr); end
    rd_addr = 0; rd_we = 1; is_load = 1; rs1_addr = 0; rs2_addr = 0;
    tick();
    n_tests++;
    if ({ex_valid, ex_rd_we, ex_is_load, ex_rd_addr} !== {3'b111, 5'd0})
      begin n_fail++; $display("FAIL rd0_load: got %b/%0d want 111/0", {ex_valid, ex_rd_we, ex_is_load}, ex_rd_addr); end
    rd_addr = 1; is_load = 0;
    #1;
    n_tests++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_no_stall: got %b want 1", id_ready); end
    tick();
  endtask

  task automatic test_bypass();
    drive_idle();
    id_valid = 1; rs1_addr = 7; A_in = 0; wb_we = 1; wb_addr = 7; wb_data = 32'hABCD;
    rs2_addr = 6; B_in = 32'h66;
    tick();
    n_tests++;
    if (ex_rs1_data !== (BYP ? 32'hABCD : 32'h0))
      begin n_fail++; $display("FAIL bypass_rs1: got %h want %h", ex_rs1_data, BYP ? 32'hABCD : 32'h0); end
    n_tests++;
    if (ex_rs2_data !== 32'h66) begin n_fail++; $display("FAIL bypass_rs2: got %h want 66", ex_rs2_data); end
  endtask

  task automatic test_hold_refresh();
    logic [W-1:0] exp1, exp2;
    drive_idle();
    id_valid = 1; rs1_addr = 4; A_in = 32'h34; rs2_addr = 9; B_in = 32'h12;
    rd_addr = 3; rd_we = 1; pc = 32'h200; imm = 32'h8;
    tick();
    ex_ready = 0; rs1_addr = 11; rs2_addr = 12; rd_addr = 13; pc = 32'h999;
    A_in = 1; B_in = 2; imm = 5; wb_we = 1; wb_addr = 9; wb_data = 32'h55;
    #1;
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_id_ready: got %b want 0", id_ready); end
    tick();
    exp2 = BYP ? 32'h55 : 32'h12;
    n_tests++;
    if (ex_rs2_data !== exp2) begin n_fail++; $display("FAIL hold_refresh_rs2: got %h want %h", ex_rs2_data, exp2); end
    n_tests++;
    if ({ex_valid, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_pc, ex_imm} !==
        {1'b1, 5'd4, 5'd9, 5'd3, 32'h34, 32'h200, 32'h8})
      begin n_fail++; $display("FAIL hold_keep: got %b/%0d/%0d/%0d/%h/%h/%h", ex_valid, ex_rs1_addr,
                               ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_pc, ex_imm); end
    wb_addr = 4; wb_data = 32'h77;
    tick();
    exp1 = BYP ? 32'h77 : 32'h34;
    n_tests++;
    if ({ex_rs1_data, ex_rs2_data} !== {exp1, exp2})
      begin n_fail++; $display("FAIL hold_refresh_rs1: got %h/%h want %h/%h", ex_rs1_data, ex_rs2_data, exp1, exp2); end
    wb_addr = 0; wb_data = 32'hDEAD;
    tick();
    n_tests++;
    if ({ex_rs1_data, ex_rs2_data} !== {exp1, exp2})
      begin n_fail++; $display("FAIL hold_x0_write: got %h/%h want %h/%h", ex_rs1_data, ex_rs2_data, exp1, exp2); end
  endtask

  task automatic test_flush_hold();
    wb_we = 0; ex_ready = 0; flush = 1;
    #1;
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_id_ready: got %b want 0", id_ready); end
    tick();
    n_tests++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    flush = 0;
  endtask

  task automatic test_x0_reset();
    drive_idle();
    id_valid = 1; rs1_addr = 0; A_in = 32'hFFFF; rs2_addr = 0; B_in = 32'hFFFF;
    wb_we = 1; wb_addr = 0; wb_data = 32'h1234; rd_addr = 2;
    tick();
    n_tests++;
    if ({ex_valid, ex_rs1_data, ex_rs2_data} !== {1'b1, 32'h0, 32'h0})
      begin n_fail++; $display("FAIL x0_operand: got %b/%h/%h want 1/0/0", ex_valid, ex_rs1_data, ex_rs2_data); end
    drive_idle();
    id_valid = 1; rs1_addr = 5; A_in = 32'h5A; rd_addr = 7; rd_we = 1; is_load = 1;
    pc = 32'h40; imm = 32'h10;
    tick();
    ex_ready = 0; rs2_addr = 7;
    tick();
    n_tests++;
    if ({ex_valid, ex_rs1_data} !== {1'b1, 32'h5A})
      begin n_fail++; $display("FAIL held_before_reset: got %b/%h want 1/5a", ex_valid, ex_rs1_data); end
    #2 reset = 0;
    #1;
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", dut_vec); end
    n_tests++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b want 0", id_ready); end
    #1 reset = 1;
    tick();
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_discard: got %h want 0", dut_vec); end
  endtask

  task automatic test_random();
    ex_t m, mn;
    bit  known, known_n, exp_ready;
    drive_idle();
    reset = 0;
    #1 reset = 1;
    m = '0; known = 1;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      rs1_addr = AW'($urandom_range(0, 7)); rs2_addr = AW'($urandom_range(0, 7));
      rd_addr  = AW'($urandom_range(0, 7)); rd_we = $urandom_range(0, 1) != 0;
      is_load  = ($urandom_range(0, 4) < 2);
      pc = $urandom; imm = $urandom; A_in = $urandom; B_in = $urandom;
      wb_we = $urandom_range(0, 1) != 0; wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0); ex_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        reset = 0;
        #1;
        n_tests++;
        if ({dut_vec, id_ready} !== '0) begin n_fail++; $display("FAIL rand_reset[%0d]: got %h want 0", i, dut_vec); end
        m = '0; known = 1;
        reset = 1;
      end
      #1;
      exp_ready = ex_ready && !flush && !model_hazard(m);
      n_tests++;
      if (id_ready !== exp_ready)
        begin n_fail++; $display("FAIL rand_id_ready[%0d]: got %b want %b", i, id_ready, exp_ready); end
      mn = model_next(m);
      known_n = flush ? 1'b0 : ((ex_ready && !model_hazard(m)) ? 1'b1 : known);
      tick();
      m = mn; known = known_n;
      n_tests++;
      if (known ? (dut_vec !== m) : (ex_valid !== m.valid))
        begin n_fail++; $display("FAIL rand_ex[%0d]: got %h want %h", i, dut_vec, m); end
    end
  endtask

  initial begin
    test_reset();
    test_plain_load();
    test_load_use();
    test_bypass();
    test_hold_refresh();
    test_flush_hold();
    test_x0_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter mem_width, default 32: data/operand width in bits.
REQ-002 Parameter mem_depth, default 32: register count; address width is $clog2(mem_depth).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  decode slot holds a valid instruction.
REQ-006 rs1_addr, rs2_addr, rd_addr  in  addr width  decoded source/destination indices.
REQ-007 rd_we, is_load  in  1  decoded write-enable and load flag.
REQ-008 pc, imm  in  mem_width  decoded PC and sign-extended immediate.
REQ-009 A_in, B_in  in  mem_width  register file read data for rs1/rs2.
REQ-010 wb_we, wb_addr, wb_data  in  1/addr/mem_width  write-back port (same values driven to the register file).
REQ-011 flush  in  1  kill the instruction entering EX.
REQ-012 ex_ready  in  1  EX accepts a new instruction this cycle.
REQ-013 id_ready  out  1  decode may advance this cycle.
REQ-014 ex_valid, ex_rd_we, ex_is_load  out  1  registered EX control.
REQ-015 ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  addr width  registered indices.
REQ-016 ex_rs1_data, ex_rs2_data, ex_pc, ex_imm  out  mem_width  registered operands.

Function
REQ-017 load_use SHALL be high when id_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd_addr!=0 & (ex_rd_addr==rs1_addr | ex_rd_addr==rs2_addr).
REQ-018 id_ready SHALL equal ex_ready & ~load_use & ~flush, combinationally.
REQ-019 Priority per edge: flush > hold (ex_ready=0) > bubble (load_use) > load.
REQ-020 flush: ex_valid <= 0 next edge regardless of ex_ready; other EX fields don't-care.
REQ-021 hold: every EX register keeps its value, except operand refresh per REQ-024.
REQ-022 bubble: ex_valid <= 0, ex_rd_we <= 0, ex_is_load <= 0; decode slot is retained and re-presented next cycle.
REQ-023 load: all EX fields <= decode inputs, ex_valid <= id_valid; latency exactly one cycle.
REQ-024 Operand refresh: during hold, if wb_we & wb_addr!=0 & wb_addr==ex_rsN_addr, ex_rsN_data <= wb_data.
REQ-025 Index 0: captured operand for rsN_addr==0 SHALL be 0 regardless of A_in/B_in or bypass.
REQ-026 rd_addr==0 with rd_we=1 SHALL be loaded as given; it never triggers load_use.

Reset
REQ-027 On reset low, immediately: ex_valid, ex_rd_we, ex_is_load = 0; all address and data outputs = 0.
REQ-028 id_ready SHALL be 0 while reset is low; first load occurs on the first edge after release.
REQ-029 Reset mid-stall SHALL discard the held instruction; no state survives.

Configuration
REQ-030 Macro WB_BYPASS_EN defined: on load, if wb_we & wb_addr!=0 & wb_addr==rsN_addr, capture wb_data instead of A_in/B_in (write-through); REQ-024 refresh active.
REQ-031 Macro WB_BYPASS_EN undefined: operands captured from A_in/B_in only; REQ-024 disabled; the register file is relied on for write-before-read.

Structure
REQ-032 Shared package SHALL hold XLEN=32, REG_COUNT=32, REG_ADDR_W=5, and the typedef of the EX control bundle (valid, rd_we, is_load, rd_addr).
REQ-033 One sub-module, hazard_detect, SHALL compute load_use combinationally; all registers stay in id_ex_stage.

Verification
REQ-034 Plain load: id_valid=1, rs1=3, A_in=0x11, imm=0x4, ex_ready=1 -> next cycle ex_valid=1, ex_rs1_data=0x11, ex_imm=0x4.
REQ-035 Load-use: EX holds lw rd=5; decode rs2=5 -> id_ready=0, next cycle ex_valid=0, following cycle decode loads with ex_valid=1.
REQ-036 Bypass (WB_BYPASS_EN): rs1=7, A_in=0x0, wb_we=1, wb_addr=7, wb_data=0xABCD -> ex_rs1_data=0xABCD; without macro -> 0x0.
REQ-037 Hold refresh: ex_ready=0, ex_rs2_addr=9, wb write x9=0x55 -> ex_rs2_data=0x55 while held, other fields unchanged.
REQ-038 Flush during hold: ex_ready=0, flush=1 -> next cycle ex_valid=0, id_ready=0 that cycle.
REQ-039 x0 and reset: rs1=0, A_in=0xFFFF, wb write to x0 -> ex_rs1_data=0; assert reset mid-hold -> all outputs 0 asynchronously.
